// File: rtl/spmmio_initiator.sv
// Purpose     : spmmio bus initiator; one request in, one registered cs/adr/sel/we/d access out, read data back.
// Latency     : cs rises 1 cycle after accept and stays high WAIT_CYCLES+1 cycles; read data is valid from accept+2+WAIT_CYCLES.
// Backpressure: req_ready is high only in IDLE; a read response is held in RESP until rsp_ready.
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_we, req_adr, req_sel, req_d carry the request
//   rsp_valid/rsp_ready      read response handshake; rsp_q carries the read data
//   busy                     high whenever the FSM is not in IDLE
//   cs, adr, sel, we, d      registered bus outputs towards spmmio responders
//   q                        combinational read data from the addressed responder
// Optional build macro SPMMIO_INITIATOR_POLL_EN adds req_poll, req_mask, req_match and rsp_timeout:
//   a polled read repeats the access until (q & req_mask) == req_match or POLL_MAX accesses are done.
module spmmio_initiator #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned POLL_MAX    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [0:3]  req_adr,
  input  logic [0:3]  req_sel,
  input  logic [0:31] req_d,
`ifdef SPMMIO_INITIATOR_POLL_EN
  input  logic        req_poll,
  input  logic [0:31] req_mask,
  input  logic [0:31] req_match,
  output logic        rsp_timeout,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:31] rsp_q,
  output logic        busy,
  output logic        cs,
  output logic [0:3]  adr,
  output logic [0:3]  sel,
  output logic        we,
  output logic [0:31] d,
  input  logic [0:31] q
);

  // Wait counter is 4 bits and the poll iteration counter is 8 bits.
  if (WAIT_CYCLES > 15 || POLL_MAX < 1 || POLL_MAX > 255) begin : g_param_check
    $error("spmmio_initiator: WAIT_CYCLES or POLL_MAX out of range");
  end

  // S_GAP is the single cs-low cycle between polled read iterations.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [0:3]  adr_q, adr_d;
  logic [0:3]  sel_q, sel_d;
  logic [0:31] dat_q, dat_d;
  logic [0:31] rdat_q, rdat_d;

`ifdef SPMMIO_INITIATOR_POLL_EN
  logic        poll_q, poll_d;
  logic [0:31] mask_q, mask_d;
  logic [0:31] match_q, match_d;
  logic [7:0]  iter_q, iter_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  iter_inc;
  logic        poll_hit;
  logic        poll_limit;

  // Completed-access count saturates instead of wrapping.
  assign iter_inc   = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
  assign poll_hit   = ((q & mask_q) == match_q);
  assign poll_limit = (32'(iter_inc) >= POLL_MAX);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
`ifdef SPMMIO_INITIATOR_POLL_EN
    poll_d  = poll_q;
    mask_d  = mask_q;
    match_d = match_q;
    iter_d  = iter_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          adr_d   = req_adr;
          sel_d   = req_sel;
          we_d    = req_we;
          dat_d   = req_d;
          cs_d    = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_ACCESS;
`ifdef SPMMIO_INITIATOR_POLL_EN
          poll_d  = req_poll & ~req_we;
          mask_d  = req_mask;
          match_d = req_match;
          iter_d  = 8'd0;
          tmo_d   = 1'b0;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last access cycle: cs/we drop, adr/sel/d keep their values.
          cs_d = 1'b0;
          we_d = 1'b0;
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            rdat_d = q;
`ifdef SPMMIO_INITIATOR_POLL_EN
            iter_d = iter_inc;
            if (poll_q && !poll_hit && !poll_limit) begin
              state_d = S_GAP;
            end else begin
              state_d = S_RESP;
              tmo_d   = poll_q && !poll_hit;
            end
`else
            state_d = S_RESP;
`endif
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        cs_d    = 1'b1;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = S_ACCESS;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
    end
  end

`ifdef SPMMIO_INITIATOR_POLL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_q  <= 1'b0;
      mask_q  <= '0;
      match_q <= '0;
      iter_q  <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      poll_q  <= poll_d;
      mask_q  <= mask_d;
      match_q <= match_d;
      iter_q  <= iter_d;
      tmo_q   <= tmo_d;
    end
  end

  assign rsp_timeout = tmo_q;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_q     = rdat_q;
  assign cs        = cs_q;
  assign we        = we_q;
  assign adr       = adr_q;
  assign sel       = sel_q;
  assign d         = dat_q;

endmodule

// File: tb/tb_spmmio_initiator.sv
// Purpose     : directed self-checking bench for spmmio_initiator (WAIT_CYCLES=0 and WAIT_CYCLES=3 instances).
// Latency     : expectations are cycle-exact; outputs are sampled on the falling clock edge.
// Backpressure: rsp_ready is held low/high by the scenarios to exercise response stalls.
module tb_spmmio_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance with WAIT_CYCLES=0
  logic        r0_valid, r0_rdy, r0_we;
  logic [0:3]  r0_adr, r0_sel;
  logic [0:31] r0_d;
  logic        p0_valid, p0_ready;
  logic [0:31] p0_q;
  logic        busy0, cs0, we0;
  logic [0:3]  adr0, sel0;
  logic [0:31] d0, q0, q0_val;

  // Instance with WAIT_CYCLES=3
  logic        r3_valid, r3_rdy, r3_we;
  logic [0:3]  r3_adr, r3_sel;
  logic [0:31] r3_d;
  logic        p3_valid, p3_ready;
  logic [0:31] p3_q;
  logic        busy3, cs3, we3;
  logic [0:3]  adr3, sel3;
  logic [0:31] d3, q3, q3_val;

`ifdef SPMMIO_INITIATOR_POLL_EN
  logic        poll0, poll3, tmo0, tmo3;
  logic [0:31] mask0, match0, mask3, match3;
`endif

  // Responder models: data is only meaningful while cs is high.
  assign q0 = cs0 ? q0_val : 32'hDEAD_BEEF;
  assign q3 = cs3 ? q3_val : 32'hDEAD_BEEF;

  int pulses0 = 0;
  always @(posedge cs0) pulses0 = pulses0 + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  spmmio_initiator #(.WAIT_CYCLES(0), .POLL_MAX(4)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(r0_valid), .req_ready(r0_rdy), .req_we(r0_we),
    .req_adr(r0_adr), .req_sel(r0_sel), .req_d(r0_d),
`ifdef SPMMIO_INITIATOR_POLL_EN
    .req_poll(poll0), .req_mask(mask0), .req_match(match0), .rsp_timeout(tmo0),
`endif
    .rsp_valid(p0_valid), .rsp_ready(p0_ready), .rsp_q(p0_q),
    .busy(busy0), .cs(cs0), .adr(adr0), .sel(sel0), .we(we0), .d(d0), .q(q0)
  );

  spmmio_initiator #(.WAIT_CYCLES(3), .POLL_MAX(4)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_valid), .req_ready(r3_rdy), .req_we(r3_we),
    .req_adr(r3_adr), .req_sel(r3_sel), .req_d(r3_d),
`ifdef SPMMIO_INITIATOR_POLL_EN
    .req_poll(poll3), .req_mask(mask3), .req_match(match3), .rsp_timeout(tmo3),
`endif
    .rsp_valid(p3_valid), .rsp_ready(p3_ready), .rsp_q(p3_q),
    .busy(busy3), .cs(cs3), .adr(adr3), .sel(sel3), .we(we3), .d(d3), .q(q3)
  );

  task automatic test_reset();
    reset = 1'b0;
    r0_valid = 1'b0; r0_we = 1'b0; r0_adr = '0; r0_sel = '0; r0_d = '0; p0_ready = 1'b0; q0_val = '0;
    r3_valid = 1'b0; r3_we = 1'b0; r3_adr = '0; r3_sel = '0; r3_d = '0; p3_ready = 1'b0; q3_val = '0;
`ifdef SPMMIO_INITIATOR_POLL_EN
    poll0 = 1'b0; mask0 = '0; match0 = '0;
    poll3 = 1'b0; mask3 = '0; match3 = '0;
`endif
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({cs0, we0, busy0, r0_rdy, p0_valid} !== 5'b00010)
      $display("FAIL reset_ctl0: got %b want 00010", {cs0, we0, busy0, r0_rdy, p0_valid});
    else pass_cnt++;
    total_cnt++;
    if ({adr0, sel0, d0, p0_q} !== 72'h0)
      $display("FAIL reset_bus0: adr=%h sel=%h d=%h rsp_q=%h want all 0", adr0, sel0, d0, p0_q);
    else pass_cnt++;
    total_cnt++;
    if ({cs3, busy3, r3_rdy, p3_valid} !== 4'b0010)
      $display("FAIL reset_ctl3: got %b want 0010", {cs3, busy3, r3_rdy, p3_valid});
    else pass_cnt++;
`ifdef SPMMIO_INITIATOR_POLL_EN
    total_cnt++;
    if (tmo0 !== 1'b0) $display("FAIL reset_timeout: got %b want 0", tmo0);
    else pass_cnt++;
`endif
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit seen;
    r0_valid = 1'b1; r0_we = 1'b1; r0_adr = 4'h0; r0_sel = 4'b0001; r0_d = 32'h0000_0003;
    total_cnt++;
    if (r0_rdy !== 1'b1) $display("FAIL write_ready: got %b want 1", r0_rdy);
    else pass_cnt++;
    @(negedge clk);
    r0_valid = 1'b0;
    total_cnt++;
    if ({cs0, we0, busy0, r0_rdy, p0_valid} !== 5'b11100)
      $display("FAIL write_access: got %b want 11100", {cs0, we0, busy0, r0_rdy, p0_valid});
    else pass_cnt++;
    total_cnt++;
    if ({adr0, sel0, d0} !== {4'h0, 4'h1, 32'h0000_0003})
      $display("FAIL write_bus: adr=%h sel=%h d=%h want 0 1 00000003", adr0, sel0, d0);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cs0, we0, busy0, r0_rdy, p0_valid} !== 5'b00010)
      $display("FAIL write_end: got %b want 00010", {cs0, we0, busy0, r0_rdy, p0_valid});
    else pass_cnt++;
    total_cnt++;
    if ({adr0, d0} !== {4'h0, 32'h0000_0003})
      $display("FAIL write_hold: adr=%h d=%h want 0 00000003", adr0, d0);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | p0_valid | cs0;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL write_no_rsp: saw rsp_valid/cs=%b want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_read();
    bit held;
    q0_val = 32'h0000_0002;
    r0_valid = 1'b1; r0_we = 1'b0; r0_adr = 4'h0; r0_sel = 4'hF;
    @(negedge clk);
    r0_valid = 1'b0;
    total_cnt++;
    if ({cs0, we0, p0_valid} !== 3'b100)
      $display("FAIL read_access: got %b want 100", {cs0, we0, p0_valid});
    else pass_cnt++;
    @(negedge clk);
    q0_val = 32'h0000_0077;
    total_cnt++;
    if ({cs0, p0_valid, busy0} !== 3'b011 || p0_q !== 32'h0000_0002)
      $display("FAIL read_rsp: ctl=%b q=%h want 011 00000002", {cs0, p0_valid, busy0}, p0_q);
    else pass_cnt++;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      held = held & p0_valid & (p0_q == 32'h0000_0002);
    end
    total_cnt++;
    if (held !== 1'b1) $display("FAIL read_stall: held=%b want 1", held);
    else pass_cnt++;
    p0_ready = 1'b1;
    @(negedge clk);
    p0_ready = 1'b0;
    total_cnt++;
    if ({p0_valid, busy0, r0_rdy} !== 3'b001)
      $display("FAIL read_done: got %b want 001", {p0_valid, busy0, r0_rdy});
    else pass_cnt++;
  endtask

  task automatic test_read_ready_early();
    p0_ready = 1'b1;
    q0_val = 32'hA5A5_0F0F;
    r0_valid = 1'b1; r0_we = 1'b0; r0_adr = 4'h7;
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (p0_valid !== 1'b1 || p0_q !== 32'hA5A5_0F0F)
      $display("FAIL early_rsp: valid=%b q=%h want 1 a5a50f0f", p0_valid, p0_q);
    else pass_cnt++;
    @(negedge clk);
    p0_ready = 1'b0;
    total_cnt++;
    if ({p0_valid, r0_rdy} !== 2'b01)
      $display("FAIL early_done: got %b want 01", {p0_valid, r0_rdy});
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    bit all_high;
    q3_val = 32'h0000_0001;
    r3_valid = 1'b1; r3_we = 1'b0; r3_adr = 4'h9; r3_sel = 4'hF;
    all_high = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r3_valid = 1'b0;
      all_high = all_high & cs3;
      if (i == 3) q3_val = 32'h0000_0005;
    end
    total_cnt++;
    if (all_high !== 1'b1) $display("FAIL wait_cs_len: cs high 4 cycles=%b want 1", all_high);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cs3, p3_valid} !== 2'b01 || p3_q !== 32'h0000_0005)
      $display("FAIL wait_rsp: ctl=%b q=%h want 01 00000005", {cs3, p3_valid}, p3_q);
    else pass_cnt++;
    total_cnt++;
    if (adr3 !== 4'h9) $display("FAIL wait_adr_hold: got %h want 9", adr3);
    else pass_cnt++;
    p3_ready = 1'b1;
    @(negedge clk);
    p3_ready = 1'b0;
    total_cnt++;
    if ({p3_valid, r3_rdy} !== 2'b01) $display("FAIL wait_done: got %b want 01", {p3_valid, r3_rdy});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    r0_valid = 1'b1; r0_we = 1'b1; r0_adr = 4'h1; r0_sel = 4'hF; r0_d = 32'hAAAA_0001;
    @(negedge clk);
    total_cnt++;
    if ({cs0, r0_rdy} !== 2'b10 || {adr0, d0} !== {4'h1, 32'hAAAA_0001})
      $display("FAIL b2b_first: ctl=%b adr=%h d=%h want 10 1 aaaa0001", {cs0, r0_rdy}, adr0, d0);
    else pass_cnt++;
    r0_adr = 4'h2; r0_d = 32'hBBBB_0002;
    @(negedge clk);
    total_cnt++;
    if ({cs0, r0_rdy} !== 2'b01 || d0 !== 32'hAAAA_0001)
      $display("FAIL b2b_gap: ctl=%b d=%h want 01 aaaa0001", {cs0, r0_rdy}, d0);
    else pass_cnt++;
    @(negedge clk);
    r0_valid = 1'b0;
    total_cnt++;
    if ({cs0, we0} !== 2'b11 || {adr0, d0} !== {4'h2, 32'hBBBB_0002})
      $display("FAIL b2b_second: ctl=%b adr=%h d=%h want 11 2 bbbb0002", {cs0, we0}, adr0, d0);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cs0, busy0, p0_valid} !== 3'b000)
      $display("FAIL b2b_end: got %b want 000", {cs0, busy0, p0_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    q0_val = 32'h0BAD_0BAD;
    r0_valid = 1'b1; r0_we = 1'b0; r0_adr = 4'h3;
    @(negedge clk);
    r0_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({cs0, busy0, p0_valid, r0_rdy} !== 4'b0001)
      $display("FAIL rst_access: got %b want 0001", {cs0, busy0, p0_valid, r0_rdy});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    r0_valid = 1'b1;
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (p0_valid !== 1'b1) $display("FAIL rst_pre_resp: valid=%b want 1", p0_valid);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({p0_valid, busy0} !== 2'b00 || p0_q !== 32'h0)
      $display("FAIL rst_resp: ctl=%b q=%h want 00 00000000", {p0_valid, busy0}, p0_q);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    q0_val = 32'h1234_5678;
    r0_valid = 1'b1;
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (p0_valid !== 1'b1 || p0_q !== 32'h1234_5678)
      $display("FAIL rst_after_read: valid=%b q=%h want 1 12345678", p0_valid, p0_q);
    else pass_cnt++;
    p0_ready = 1'b1;
    @(negedge clk);
    p0_ready = 1'b0;
  endtask

`ifdef SPMMIO_INITIATOR_POLL_EN
  task automatic test_poll(input bit match_late, input int exp_pulses, input bit exp_tmo);
    int start;
    int gaps;
    bit got;
    q0_val = 32'h0;
    start = pulses0;
    gaps = 0;
    got = 1'b0;
    r0_valid = 1'b1; r0_we = 1'b0; r0_adr = 4'h5; poll0 = 1'b1; mask0 = 32'h80; match0 = 32'h80;
    @(negedge clk);
    r0_valid = 1'b0; poll0 = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      if (match_late && (pulses0 - start) >= 3) q0_val = 32'h0000_0080;
      if (p0_valid) got = 1'b1;
      else begin
        if (busy0 && !cs0) gaps++;
        @(negedge clk);
      end
    end
    total_cnt++;
    if (got !== 1'b1) $display("FAIL poll_rsp_seen: no rsp_valid within budget");
    else pass_cnt++;
    total_cnt++;
    if ((pulses0 - start) !== exp_pulses)
      $display("FAIL poll_pulses: got %0d want %0d", pulses0 - start, exp_pulses);
    else pass_cnt++;
    total_cnt++;
    if (gaps !== exp_pulses - 1) $display("FAIL poll_gaps: got %0d want %0d", gaps, exp_pulses - 1);
    else pass_cnt++;
    total_cnt++;
    if (p0_q !== (match_late ? 32'h0000_0080 : 32'h0) || tmo0 !== exp_tmo)
      $display("FAIL poll_result: q=%h tmo=%b want %h %b", p0_q, tmo0,
               (match_late ? 32'h0000_0080 : 32'h0), exp_tmo);
    else pass_cnt++;
    p0_ready = 1'b1;
    @(negedge clk);
    p0_ready = 1'b0;
    total_cnt++;
    if ({p0_valid, r0_rdy} !== 2'b01) $display("FAIL poll_done: got %b want 01", {p0_valid, r0_rdy});
    else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_ready_early();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
`ifdef SPMMIO_INITIATOR_POLL_EN
    test_poll(1'b1, 3, 1'b0);
    test_poll(1'b0, 4, 1'b1);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spmmio_initiator.md
Name: spmmio_initiator

Overview:
- Bus initiator for the spmmio peripheral bus. It drives the same cs/adr/sel/we/d/q signals that spmmio responder blocks (misc LEDs and others) decode.
- Accepts single read/write requests over a valid/ready handshake, runs one bus access with configurable wait states, and returns read data over a valid/ready response channel.
- Sits between the soft-CPU/debug bridge and the spmmio peripheral address space.

Parameters:
- WAIT_CYCLES, 0: extra cycles cs is held beyond the first access cycle. Range 0..15.
- POLL_MAX, 255: maximum poll read iterations. Used only with SPMMIO_INITIATOR_POLL_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  [0:3]  register address.
- req_sel  in  [0:3]  byte selects; sel[3] is the LSB byte d[24:31].
- req_d  in  [0:31]  write data.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_q  out  [0:31]  read data.
- busy  out  1  high in any state except IDLE.
- cs  out  1  bus chip select.
- adr  out  [0:3]  bus address.
- sel  out  [0:3]  bus byte selects.
- we  out  1  bus write enable.
- d  out  [0:31]  bus write data.
- q  in  [0:31]  bus read data; combinational from the responder, valid while cs is high.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; cs=0, we=0, adr=0, sel=0, d=0, rsp_valid=0, rsp_q=0, req_ready=1, busy=0. Wait counter is cleared.
- All bus outputs are registered. req_ready is 1 only in IDLE.
- IDLE:
  - On accept: latch adr/sel/we/d from req_*, set cs=1, load wait counter with WAIT_CYCLES, and go to ACCESS. The first access cycle is the cycle after the accept.
- ACCESS:
  - cs stays high and adr/sel/we/d are held stable.
  - If counter != 0, decrement it.
  - If counter == 0, this is the last access cycle:
    - Drop cs and we next edge; adr/sel/d keep their last values.
    - Read: capture q into rsp_q at this edge and go to RESP.
    - Write: go to IDLE.
  - Total cs-high time is WAIT_CYCLES+1 cycles.
- RESP:
  - rsp_valid=1 and rsp_q is held stable until the handshake.
  - On rsp_ready: rsp_valid=0 and go to IDLE next edge.
  - rsp_ready may already be high on entry; RESP still lasts at least one cycle.
- Latency:
  - Write: req accept to cs rising is 1 cycle; back-to-back writes give cs low for 1 cycle between accesses.
  - Read with WAIT_CYCLES=0: accept at edge N, cs high cycle N+1, rsp_valid from edge N+2.
- Writes generate no response. Requests are never dropped or reordered.
- req_* are ignored when req_ready=0. rsp_ready is ignored when rsp_valid=0.
- Reset asserted mid-access forces cs=0 immediately (asynchronous); any in-flight response is discarded.

Optional Feature:
- Macro SPMMIO_INITIATOR_POLL_EN.
- When defined, adds these ports:
  - req_poll in 1.
  - req_mask in [0:31].
  - req_match in [0:31].
  - rsp_timeout out 1 (reset 0, valid with rsp_valid).
- A read with req_poll=1 repeats the full read access until (q & req_mask) == req_match, or until POLL_MAX accesses have completed.
  - cs drops for exactly 1 cycle between iterations.
  - The last q sampled goes to rsp_q.
  - rsp_timeout=1 only if no match occurred within POLL_MAX iterations.
  - The iteration counter is 8 bits and saturates; it never wraps.
- When undefined: ports absent, and all reads are single-shot.

Test Plan:
- Write req adr=0, sel=4'b0001, d=32'h00000003, WAIT_CYCLES=0 → cs=1 and we=1 for exactly 1 cycle, one cycle after accept, with adr=0 and d=3; no rsp_valid.
- Read adr=0 with responder model driving q=32'h00000002 while cs=1 → rsp_valid at accept+2 with rsp_q=32'h00000002; held while rsp_ready=0 for 5 cycles.
- WAIT_CYCLES=3, read → cs high 4 cycles; q changed from 32'h1 to 32'h5 in the last cs cycle → rsp_q=32'h5.
- Two writes presented back-to-back with req_valid held high → req_ready low during ACCESS; two cs pulses separated by 1 low cycle; data order preserved.
- reset driven low during ACCESS → cs=0, busy=0, and rsp_valid=0 without waiting for a clock edge; after release, a new read completes normally.
- POLL_EN, POLL_MAX=4:
  - q=0 for 2 iterations then 32'h80, mask=match=32'h80 → 3 cs pulses, rsp_q=32'h80, rsp_timeout=0.
  - q stuck at 0 → 4 pulses, rsp_timeout=1.
